// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared encodings for the load/store data memory.
//   size_e    - request access size (byte / half / word / illegal)
//   state_e   - controller states (CLEAR zero-fills the RAM, RUN serves requests)
//   rsp_ctx_t - request attributes carried to the response stage
//   is_misaligned / lane_mask - alignment check and byte-write-enable helpers
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Everything the response stage needs to format a load after the RAM read.
    typedef struct packed {
        logic       err;
        logic       load;
        size_e      size;
        logic       uns;
        logic [1:0] off;
    } rsp_ctx_t;

    // Illegal size counts as misaligned: both are reported through rsp_err.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Byte-write-enable for an aligned store.
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bank.sv
// data_mem_bank: 2^DEPTH_W x 32-bit single-port RAM, one 8-bit array per byte lane.
//   clk   - clock
//   addr  - word address (shared by read and write)
//   we    - per-byte write enable, little-endian (we[0] -> bits [7:0])
//   wdata - write data
//   rdata - registered read data of addr (old contents if written the same edge)
module data_mem_bank #(
    parameter int DEPTH_W = 10
) (
    input  logic               clk,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [3:0]         we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    localparam int DEPTH = 2 ** DEPTH_W;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[g]) mem[addr] <= wdata[g*8 +: 8];
            rd_q <= mem[addr];
        end

        assign rdata[g*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_ls.sv
// data_mem_ls: byte/half/word load-store data memory with optional zero-fill
// after reset.
//   clk, rst     - clock, synchronous active-high reset
//   req_*        - request channel (valid/ready handshake, one per cycle)
//   rsp_valid    - one-cycle pulse, one cycle after an accepted request
//   rsp_rdata    - extended load data (0 for stores and errors)
//   rsp_err      - misaligned or illegal-size request
//   busy         - high while the RAM is being zero-filled
module data_mem_ls
    import data_mem_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int DEPTH_W = ADDR_W - 2;

    state_e             state;
    logic [DEPTH_W-1:0] clr_cnt;
    logic               rsp_vld_q;
    rsp_ctx_t           ctx_q;

    size_e              size;
    logic [1:0]         off;
    logic               accept;
    logic               misal;
    logic               clearing;

    logic [DEPTH_W-1:0] bank_addr;
    logic [3:0]         bank_we;
    logic [31:0]        bank_wdata;
    logic [31:0]        bank_rdata;
    logic [31:0]        st_data;

    assign size     = size_e'(req_size);
    assign off      = req_addr[1:0];
    // ready is masked by rst so nothing is accepted in a reset cycle
    assign req_ready = (state == ST_RUN) && !rst;
    assign accept    = req_valid && req_ready;
    assign misal     = is_misaligned(size, off);
    assign clearing  = (state == ST_CLEAR) && !rst;
    assign busy      = (state == ST_CLEAR);

    // Replicate store data across lanes; the write mask picks the live ones.
    always_comb begin
        case (size)
            SZ_BYTE: st_data = {4{req_wdata[7:0]}};
            SZ_HALF: st_data = {2{req_wdata[15:0]}};
            default: st_data = req_wdata;
        endcase
    end

    always_comb begin
        bank_addr  = req_addr[ADDR_W-1:2];
        bank_wdata = st_data;
        bank_we    = 4'b0000;
        if (clearing) begin
            bank_addr  = clr_cnt;
            bank_wdata = '0;
            bank_we    = 4'b1111;
        end else if (accept && req_we && !misal) begin
            bank_we = lane_mask(size, off);
        end
    end

    data_mem_bank #(
        .DEPTH_W (DEPTH_W)
    ) u_bank (
        .clk   (clk),
        .addr  (bank_addr),
        .we    (bank_we),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt   <= '0;
            rsp_vld_q <= 1'b0;
            ctx_q     <= '0;
        end else begin
            if (state == ST_CLEAR) begin
                if (&clr_cnt) state <= ST_RUN;
                clr_cnt <= clr_cnt + 1'b1;
            end
            rsp_vld_q <= accept;
            if (accept) begin
                ctx_q.err  <= misal;
                ctx_q.load <= !req_we;
                ctx_q.size <= size;
                ctx_q.uns  <= req_unsigned;
                ctx_q.off  <= off;
            end
        end
    end

    // Response formatting works on the registered RAM output; a store one
    // cycle earlier has already committed, so loads never see stale data.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = bank_rdata[{ctx_q.off, 3'b000} +: 8];
        ld_half = ctx_q.off[1] ? bank_rdata[31:16] : bank_rdata[15:0];
        case (ctx_q.size)
            SZ_BYTE: ld_data = ctx_q.uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = ctx_q.uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = bank_rdata;
        endcase
    end

    // A reset in the response cycle drops the pending response.
    assign rsp_valid = rsp_vld_q && !rst;
    assign rsp_err   = rsp_valid && ctx_q.err;
    assign rsp_rdata = (rsp_valid && ctx_q.load && !ctx_q.err) ? ld_data : 32'd0;

endmodule
